// File: rtl/slice_pkg.sv
// Shared types and constants for the slice decision stage: FSM state,
// score saturation limits and the FIFO entry layout.
package slice_pkg;

  localparam int SLICE_WPI  = 32;
  localparam int SLICE_OUTW = 16;
  localparam int SLICE_IDXW = $clog2(SLICE_WPI);

  localparam longint SAT_MAX = (longint'(1) <<< (SLICE_OUTW - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) <<< (SLICE_OUTW - 1));

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic signed [SLICE_OUTW-1:0] score;
    logic                         label;
    logic [SLICE_IDXW-1:0]        idx;
  } dec_entry_t;

  // Zero counts as negative, so positive means sign clear and non-zero.
  function automatic logic is_positive(input logic signed [SLICE_OUTW-1:0] s);
    return !s[SLICE_OUTW-1] && (s != '0);
  endfunction

endpackage

// File: rtl/slice_dec_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data whenever
// empty is low. A write into a full FIFO is taken only alongside a read.
module slice_dec_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_rd;
  logic         do_wr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/slice_decision.sv
// Per-window bias, saturation and labelling of slice accumulators, with a
// ready/valid result FIFO and per-sweep positive count / sticky overflow.
module slice_decision
  import slice_pkg::*;
#(
  parameter int WPI   = SLICE_WPI,
  parameter int ACCW  = 32,
  parameter int OUTW  = SLICE_OUTW,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dvi,
  input  logic signed [ACCW-1:0]     acc_in,
  input  logic signed [ACCW-1:0]     bias,
  input  logic                       ready_i,
  output logic                       dvo,
  output logic signed [OUTW-1:0]     score_o,
  output logic                       label_o,
  output logic [$clog2(WPI)-1:0]     win_idx_o,
  output logic                       sweep_done,
  output logic [$clog2(WPI+1)-1:0]   pos_count,
  output logic                       overflow
);

  localparam int                IDXW     = $clog2(WPI);
  localparam int                CNTW     = $clog2(WPI + 1);
  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(WPI - 1);

  fsm_state_t               state;
  logic [IDXW-1:0]          idx_q;
  logic signed [ACCW-1:0]   bias_q;
  logic signed [ACCW-1:0]   bias_eff;
  logic [CNTW-1:0]          cnt;

  logic                     vld_p1;
  logic signed [ACCW:0]     sum_p1;
  logic [IDXW-1:0]          idx_p1;
  logic signed [OUTW-1:0]   sat_p1;

  logic                     vld_p2;
  logic signed [OUTW-1:0]   score_p2;
  logic                     label_p2;
  logic [IDXW-1:0]          idx_p2;

  dec_entry_t               wr_entry;
  dec_entry_t               head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_rd;

  function automatic logic signed [OUTW-1:0] sat_score(input logic signed [ACCW:0] s);
    if (longint'(s) > SAT_MAX) return SAT_MAX[OUTW-1:0];
    if (longint'(s) < SAT_MIN) return SAT_MIN[OUTW-1:0];
    return s[OUTW-1:0];
  endfunction

  // The first window of a sweep must see the incoming bias, not the stale latch.
  assign bias_eff = (state == IDLE) ? bias : bias_q;
  assign sat_p1   = sat_score(sum_p1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx_q      <= '0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      sweep_done <= 1'b0;
      cnt        <= '0;
      pos_count  <= '0;
      overflow   <= 1'b0;
    end else begin
      vld_p1     <= dvi;
      vld_p2     <= vld_p1;
      sweep_done <= vld_p1 && (idx_p1 == LAST_IDX);

      if (dvi) begin
        unique case (state)
          IDLE: begin
            idx_q <= IDXW'(1);
            state <= SWEEP;
          end
          SWEEP: begin
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              state <= IDLE;
            end else begin
              idx_q <= idx_q + IDXW'(1);
            end
          end
        endcase
      end

      if (vld_p2) begin
        if (idx_p2 == LAST_IDX) begin
          pos_count <= cnt + CNTW'(label_p2);
          cnt       <= '0;
        end else if (label_p2) begin
          cnt <= cnt + CNTW'(1);
        end
      end

      if (vld_p2 && fifo_full && !fifo_rd) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (dvi && state == IDLE) bias_q <= bias;
    // stage 1: widened add, cannot wrap
    if (dvi) begin
      sum_p1 <= {acc_in[ACCW-1], acc_in} + {bias_eff[ACCW-1], bias_eff};
      idx_p1 <= idx_q;
    end
    // stage 2: saturate and label
    if (vld_p1) begin
      score_p2 <= sat_p1;
      label_p2 <= is_positive(sat_p1);
      idx_p2   <= idx_p1;
    end
  end

  always_comb begin
    wr_entry       = '0;
    wr_entry.score = score_p2;
    wr_entry.label = label_p2;
    wr_entry.idx   = idx_p2;
  end

  assign fifo_rd = dvo && ready_i;

  slice_dec_fifo #(
    .W     ($bits(dec_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (vld_p2),
    .wr_data (wr_entry),
    .rd_en   (fifo_rd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign dvo       = !fifo_empty;
  assign score_o   = fifo_empty ? '0 : head.score;
  assign label_o   = fifo_empty ? 1'b0 : head.label;
  assign win_idx_o = fifo_empty ? '0 : head.idx;

endmodule
